// File: rtl/hc_mmio_rd_responder.sv
// MMIO read responder for the HardCloud CSR space: queues c0 Rx MMIO reads and
// answers each with the addressed CSR value and its tid on c2 Tx, in request order.
module hc_mmio_rd_responder #(
    parameter int          HC_BUFFER_SIZE = 2,
    parameter int          REQ_FIFO_DEPTH = 4,
    parameter logic [63:0] AFU_ID_L       = 64'h0,
    parameter logic [63:0] AFU_ID_H       = 64'h0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_mmio_rd_valid,
    input  logic [15:0]                   rx_mmio_addr,
    input  logic [1:0]                    rx_mmio_len,
    input  logic [8:0]                    rx_mmio_tid,
    input  logic                          rsp_stall,
    input  logic [63:0]                   cfg_dsm,
    input  logic [31:0]                   cfg_control,
    input  logic [64*HC_BUFFER_SIZE-1:0]  cfg_buf_addr,
    input  logic [32*HC_BUFFER_SIZE-1:0]  cfg_buf_size,
    input  logic [63:0]                   afu_status,
    output logic                          tx_mmio_rd_valid,
    output logic [8:0]                    tx_mmio_tid,
    output logic [63:0]                   tx_mmio_data,
    output logic                          err_overflow,
    output logic [31:0]                   rd_count
);
    localparam int AW = $clog2(REQ_FIFO_DEPTH);
    localparam logic [63:0] DFH = {4'h1, 8'h0, 4'h0, 7'h0, 1'b1, 24'h0, 16'h0};

    // Only reads below byte 0x400 are queued, so the upper address byte is always zero.
    typedef struct packed {
        logic [7:0] addr;
        logic [1:0] len;
        logic [8:0] tid;
    } req_t;

    req_t fifo_mem [REQ_FIFO_DEPTH];

    logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic         tx_valid_q, tx_valid_d;
    logic [8:0]   tx_tid_q, tx_tid_d;
    logic [63:0]  tx_data_q, tx_data_d;
    logic         err_q, err_d;
    logic [31:0]  count_q, count_d;

    logic         fifo_empty, fifo_full, req_hit, do_push, do_pop;
    req_t         head, new_req;
    logic [6:0]   word_idx, buf_off;
    logic [5:0]   buf_idx;
    logic [63:0]  reg_val, rsp_data;
    logic         unused_dsm_hi;

    assign unused_dsm_hi = ^cfg_dsm[63:32];

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign req_hit    = rx_mmio_rd_valid && (rx_mmio_addr[15:8] == 8'h00);
    assign do_pop     = !fifo_empty && !rsp_stall;
    // A full FIFO still takes a request when the head leaves in the same cycle.
    assign do_push    = req_hit && (!fifo_full || do_pop);
    assign new_req    = '{addr: rx_mmio_addr[7:0], len: rx_mmio_len, tid: rx_mmio_tid};
    assign head       = fifo_mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= new_req;
        end
    end

    // Decode the 64-bit register containing the head's dword address.
    always_comb begin
        reg_val  = 64'h0;
        word_idx = head.addr[7:1];
        buf_off  = word_idx - 7'h24;
        buf_idx  = buf_off[6:1];
        case (word_idx)
            7'h00:   reg_val = DFH;
            7'h01:   reg_val = AFU_ID_L;
            7'h02:   reg_val = AFU_ID_H;
            7'h20:   reg_val = afu_status;
            7'h22:   reg_val = {32'h0, cfg_dsm[31:0]};
            7'h23:   reg_val = {32'h0, cfg_control};
            default: begin
                if (word_idx >= 7'h24) begin
                    for (int k = 0; k < HC_BUFFER_SIZE; k++) begin
                        if (buf_idx == 6'(k)) begin
                            reg_val = buf_off[0] ? {32'h0, cfg_buf_size[32*k +: 32]}
                                                 : cfg_buf_addr[64*k +: 64];
                        end
                    end
                end
            end
        endcase
    end

    always_comb begin
        rsp_data = 64'h0;
        case (head.len)
            2'd0:    rsp_data = {32'h0, head.addr[0] ? reg_val[63:32] : reg_val[31:0]};
            2'd1:    rsp_data = head.addr[0] ? 64'h0 : reg_val;
            default: rsp_data = 64'h0;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tx_valid_d = do_pop;
        tx_tid_d   = tx_tid_q;
        tx_data_d  = tx_data_q;
        err_d      = err_q;
        count_d    = count_q + 32'(tx_valid_q);
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            tx_tid_d  = head.tid;
            tx_data_d = rsp_data;
        end
        if (req_hit && !do_push) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_tid_q   <= '0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_valid_q <= tx_valid_d;
            tx_tid_q   <= tx_tid_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
            count_q    <= count_d;
        end
    end

    assign tx_mmio_rd_valid = tx_valid_q;
    assign tx_mmio_tid      = tx_tid_q;
    assign tx_mmio_data     = tx_data_q;
    assign err_overflow     = err_q;
    assign rd_count         = count_q;
endmodule

// File: tb/tb_hc_mmio_rd_responder.sv
// Bench for hc_mmio_rd_responder: a queue-based reference model checked every cycle,
// plus directed reads with hand-computed expected responses.
module tb_hc_mmio_rd_responder;
    localparam int          NBUF  = 2;
    localparam int          DEPTH = 4;
    localparam logic [63:0] ID_L  = 64'hA5A5;
    localparam logic [63:0] ID_H  = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] DFH_C = 64'h1000_0100_0000_0000;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               rx_mmio_rd_valid = 1'b0;
    logic [15:0]        rx_mmio_addr = '0;
    logic [1:0]         rx_mmio_len = '0;
    logic [8:0]         rx_mmio_tid = '0;
    logic               rsp_stall = 1'b0;
    logic [63:0]        cfg_dsm = '0;
    logic [31:0]        cfg_control = '0;
    logic [64*NBUF-1:0] cfg_buf_addr = '0;
    logic [32*NBUF-1:0] cfg_buf_size = '0;
    logic [63:0]        afu_status = '0;
    logic               tx_mmio_rd_valid;
    logic [8:0]         tx_mmio_tid;
    logic [63:0]        tx_mmio_data;
    logic               err_overflow;
    logic [31:0]        rd_count;

    int checks = 0;
    int errors = 0;

    hc_mmio_rd_responder #(
        .HC_BUFFER_SIZE(NBUF),
        .REQ_FIFO_DEPTH(DEPTH),
        .AFU_ID_L(ID_L),
        .AFU_ID_H(ID_H)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_mmio_rd_valid(rx_mmio_rd_valid),
        .rx_mmio_addr(rx_mmio_addr),
        .rx_mmio_len(rx_mmio_len),
        .rx_mmio_tid(rx_mmio_tid),
        .rsp_stall(rsp_stall),
        .cfg_dsm(cfg_dsm),
        .cfg_control(cfg_control),
        .cfg_buf_addr(cfg_buf_addr),
        .cfg_buf_size(cfg_buf_size),
        .afu_status(afu_status),
        .tx_mmio_rd_valid(tx_mmio_rd_valid),
        .tx_mmio_tid(tx_mmio_tid),
        .tx_mmio_data(tx_mmio_data),
        .err_overflow(err_overflow),
        .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Register map expressed in byte addresses.
    function automatic logic [63:0] model_read(input logic [15:0] dw, input logic [1:0] len);
        int          byte_a;
        int          row;
        int          i;
        logic [63:0] r;
        byte_a = int'(dw) * 4;
        row    = byte_a - (byte_a % 8);
        r      = 64'h0;
        if (row == 'h000)      r = DFH_C;
        else if (row == 'h008) r = ID_L;
        else if (row == 'h010) r = ID_H;
        else if (row == 'h100) r = afu_status;
        else if (row == 'h110) r = {32'h0, cfg_dsm[31:0]};
        else if (row == 'h118) r = {32'h0, cfg_control};
        else if (row >= 'h120) begin
            i = (row - 'h120) / 16;
            if (i < NBUF) begin
                if ((row - 'h120) % 16 == 0) r = cfg_buf_addr[64*i +: 64];
                else                         r = {32'h0, cfg_buf_size[32*i +: 32]};
            end
        end
        if (len == 2'd1) return (byte_a % 8 != 0) ? 64'h0 : r;
        if (len == 2'd0) return (byte_a % 8 == 4) ? {32'h0, r[63:32]} : {32'h0, r[31:0]};
        return 64'h0;
    endfunction

    // Reference model: pending reads held in a ring indexed by free-running counters.
    logic [15:0] q_addr [256];
    logic [1:0]  q_len  [256];
    logic [8:0]  q_tid  [256];
    int          m_wr = 0;
    int          m_rd = 0;
    int          m_occ;
    logic        m_pop, m_acc, m_push;
    logic        exp_valid, exp_err;
    logic [8:0]  exp_tid;
    logic [63:0] exp_data;
    logic [31:0] exp_count;

    always_comb begin
        m_occ  = m_wr - m_rd;
        m_pop  = (m_occ > 0) && !rsp_stall;
        m_acc  = rx_mmio_rd_valid && (rx_mmio_addr < 16'h0100);
        m_push = m_acc && ((m_occ < DEPTH) || m_pop);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rd      <= m_wr;
            exp_valid <= 1'b0;
            exp_tid   <= '0;
            exp_data  <= '0;
            exp_err   <= 1'b0;
            exp_count <= '0;
        end else begin
            exp_valid <= m_pop;
            exp_count <= exp_count + (exp_valid ? 32'd1 : 32'd0);
            if (m_pop) begin
                exp_tid  <= q_tid[m_rd[7:0]];
                exp_data <= model_read(q_addr[m_rd[7:0]], q_len[m_rd[7:0]]);
                m_rd     <= m_rd + 1;
            end
            if (m_push) begin
                q_addr[m_wr[7:0]] <= rx_mmio_addr;
                q_len[m_wr[7:0]]  <= rx_mmio_len;
                q_tid[m_wr[7:0]]  <= rx_mmio_tid;
                m_wr              <= m_wr + 1;
            end
            if (m_acc && !m_push) exp_err <= 1'b1;
        end
    end

    always @(negedge clk) begin
        #1;
        check("valid", 64'(tx_mmio_rd_valid), 64'(exp_valid));
        check("err_overflow", 64'(err_overflow), 64'(exp_err));
        check("rd_count", 64'(rd_count), 64'(exp_count));
        if (exp_valid) begin
            check("tid", 64'(tx_mmio_tid), 64'(exp_tid));
            check("data", tx_mmio_data, exp_data);
        end
        if (tx_mmio_rd_valid) begin
            $display("rsp tid=%0d data=%h count=%0d", tx_mmio_tid, tx_mmio_data, rd_count);
        end
    end

    task automatic issue(input logic [15:0] a, input logic [1:0] l, input logic [8:0] t);
        rx_mmio_rd_valid = 1'b1;
        rx_mmio_addr     = a;
        rx_mmio_len      = l;
        rx_mmio_tid      = t;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_mmio_rd_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    logic [15:0] sw_addr [16] = '{16'h0000, 16'h0001, 16'h0000, 16'h0004, 16'h0006, 16'h0008,
                                  16'h0040, 16'h0041, 16'h0044, 16'h0046, 16'h004C, 16'h004E,
                                  16'h0050, 16'h00FF, 16'h0044, 16'h0044};
    logic [1:0]  sw_len  [16] = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0,
                                  2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd3};

    initial begin
        int n;
        cfg_buf_addr = {64'h1111_2222_3333_4444, 64'h0000_0000_CAFE_0000};
        cfg_buf_size = {32'h0000_2000, 32'h0000_1000};
        cfg_dsm      = 64'hDEAD_BEEF_0000_1000;
        cfg_control  = 32'h0000_0003;
        afu_status   = 64'h0123_4567_89AB_CDEF;
        repeat (3) @(negedge clk);
        check("reset valid", 64'(tx_mmio_rd_valid), 64'h0);
        check("reset tid", 64'(tx_mmio_tid), 64'h0);
        check("reset data", tx_mmio_data, 64'h0);
        check("reset err", 64'(err_overflow), 64'h0);
        check("reset count", 64'(rd_count), 64'h0);
        reset = 1'b0;
        idle(1);

        issue(16'h0002, 2'd1, 9'd5);
        idle(1);
        check("afu_id_l valid", 64'(tx_mmio_rd_valid), 64'h1);
        check("afu_id_l tid", 64'(tx_mmio_tid), 64'd5);
        check("afu_id_l data", tx_mmio_data, 64'hA5A5);
        idle(1);
        check("first count", 64'(rd_count), 64'd1);
        issue(16'h0049, 2'd0, 9'd6);
        idle(1);
        check("buf0 addr upper", tx_mmio_data, 64'h0);
        issue(16'h004A, 2'd0, 9'd7);
        idle(1);
        check("buf0 size", tx_mmio_data, 64'h1000);
        issue(16'h0000, 2'd1, 9'd8);
        idle(1);
        check("dfh", tx_mmio_data, 64'h1000_0100_0000_0000);
        issue(16'h0001, 2'd0, 9'd9);
        idle(1);
        check("dfh upper", tx_mmio_data, 64'h1000_0100);

        for (int i = 0; i < 16; i++) issue(sw_addr[i], sw_len[i], 9'(100 + i));
        idle(4);

        for (int i = 0; i < 10; i++) begin
            issue(16'h0044, 2'd1, 9'(20 + i));
            if (i >= 1) check("b2b tid", 64'(tx_mmio_tid), 64'(20 + i - 1));
        end
        idle(1);
        check("b2b last tid", 64'(tx_mmio_tid), 64'd29);
        idle(3);

        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);
        rsp_stall = 1'b1;
        for (int i = 1; i <= 4; i++) issue(16'h0046, 2'd0, 9'(i));
        idle(3);
        check("stalled valid", 64'(tx_mmio_rd_valid), 64'h0);
        cfg_control = 32'h0000_00F0;
        rsp_stall = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            check("drain valid", 64'(tx_mmio_rd_valid), 64'h1);
            check("drain tid", 64'(tx_mmio_tid), 64'(i));
            check("drain data", tx_mmio_data, 64'hF0);
            @(negedge clk);
        end
        check("drain count", 64'(rd_count), 64'd4);

        rsp_stall = 1'b1;
        for (int i = 0; i < 4; i++) issue(16'h0040, 2'd1, 9'(11 + i));
        check("no overflow yet", 64'(err_overflow), 64'h0);
        issue(16'h0040, 2'd1, 9'd15);
        check("overflow", 64'(err_overflow), 64'h1);
        issue(16'h0100, 2'd1, 9'd16);
        idle(2);
        rsp_stall = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (tx_mmio_rd_valid) n++;
        end
        check("overflow responses", 64'(n), 64'd4);

        rsp_stall = 1'b1;
        for (int i = 0; i < 3; i++) issue(16'h0002, 2'd1, 9'(40 + i));
        idle(1);
        rsp_stall = 1'b0;
        @(negedge clk);
        check("pre-reset valid", 64'(tx_mmio_rd_valid), 64'h1);
        check("pre-reset tid", 64'(tx_mmio_tid), 64'd40);
        reset = 1'b1;
        #1;
        check("reset valid at once", 64'(tx_mmio_rd_valid), 64'h0);
        check("reset clears err", 64'(err_overflow), 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(5);
        check("post-reset count", 64'(rd_count), 64'd0);

        rsp_stall = 1'b1;
        for (int i = 0; i < 4; i++) issue(16'h0044, 2'd1, 9'(50 + i));
        cfg_dsm = 64'h0000_0000_7777_0000;
        rsp_stall = 1'b0;
        issue(16'h0044, 2'd1, 9'd54);
        idle(8);
        check("push+pop full err", 64'(err_overflow), 64'h0);
        check("push+pop full count", 64'(rd_count), 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
